// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - state_t     : responder FSM states (IDLE / WAIT / RESP)
//   - WORD_BYTES  : bytes per memory word
//   - LANEn_LSB   : bit position of each big-endian byte lane inside a word
//   - ALIGN_MASK  : low address bits that must be zero for a word access
//   - is_aligned(): word-alignment check on the low address bits
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    // Big-endian lanes: the byte at address A carries the most significant bits.
    localparam int LANE0_LSB = 24;  // byte at A
    localparam int LANE1_LSB = 16;  // byte at A+1
    localparam int LANE2_LSB = 8;   // byte at A+2
    localparam int LANE3_LSB = 0;   // byte at A+3

    localparam logic [1:0] ALIGN_MASK = 2'(WORD_BYTES - 1);

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the processor data port and the responder.
//   req_valid/req_ready : request handshake (accept when both high at an edge)
//   req_wr              : 1 = write, 0 = read
//   req_addr            : byte address (ADDR_WIDTH bits)
//   req_wdata           : write data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata           : read data (0 for writes and errors)
//   rsp_err             : misaligned / out-of-range, valid with rsp_valid
//   err_sticky          : set by any error response, cleared only by reset
// Modports: master = requester side, slave = responder side.
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  err_sticky;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky
    );
endinterface

// File: rtl/dmem_byte_array.sv
// -----------------------------------------------------------------------------
// dmem_byte_array
// DEPTH_BYTES x 8 storage organised for big-endian 32-bit word access.
//   clk   : write clock
//   we    : write the full word at widx on the rising edge
//   widx  : word index (byte address without its two low bits)
//   wdata : word to store, bits [31:24] go to the lowest byte address
//   rdata : combinational word read at widx, same byte order
// -----------------------------------------------------------------------------
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WIDX_W      = $clog2(DEPTH_BYTES) - 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [WIDX_W-1:0] widx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    localparam int IDX_W = WIDX_W + 2;

    logic [BYTE_W-1:0] mem [DEPTH_BYTES];

    logic [IDX_W-1:0] b0, b1, b2, b3;

    assign b0 = {widx, 2'd0};
    assign b1 = {widx, 2'd1};
    assign b2 = {widx, 2'd2};
    assign b3 = {widx, 2'd3};

    assign rdata = {mem[b0], mem[b1], mem[b2], mem[b3]};

    // NOTE: the storage has no reset; clearing a RAM needs a multi-cycle
    // sequencer and would stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[b0] <= wdata[LANE0_LSB +: BYTE_W];
            mem[b1] <= wdata[LANE1_LSB +: BYTE_W];
            mem[b2] <= wdata[LANE2_LSB +: BYTE_W];
            mem[b3] <= wdata[LANE3_LSB +: BYTE_W];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Byte-addressed, big-endian word memory behind a valid/ready request and a
// one-cycle response strobe, with a programmable number of wait states.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous, active-high reset
//   bus : dmem_responder_if.slave (request/response bundle)
// Accesses are fully serialised: accept -> WAIT_STATES cycles -> RESP -> IDLE.
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_STATES = 2,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH_BYTES);
    localparam int WIDX_W = IDX_W - 2;
    localparam int CNT_W  = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    localparam logic [CNT_W-1:0]      CNT_LOAD       = CNT_W'(WAIT_STATES);
    // Highest legal word address, compared at full address width so that
    // large addresses never alias into the array.
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = ADDR_WIDTH'(DEPTH_BYTES - WORD_BYTES);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept;
    logic             enter_resp;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    logic                  acc_wr;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_err;
    logic                  mem_we;
    logic [31:0]           rd_word;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    cnt_nx = CNT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // With zero wait states RESP is entered on the accept edge itself, so the
    // access must use the live request rather than the captured copy.
    assign acc_wr    = (state == IDLE) ? bus.req_wr    : wr_q;
    assign acc_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;

    assign acc_err = !is_aligned(acc_addr[1:0]) || (acc_addr > LAST_WORD_ADDR);
    assign mem_we  = enter_resp && acc_wr && !acc_err;

    assign bus.req_ready = (state == IDLE);

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .WIDX_W      (WIDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .widx  (acc_addr[IDX_W-1:2]),
        .wdata (acc_wdata),
        .rdata (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_err    <= 1'b0;
            bus.err_sticky <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                wr_q    <= bus.req_wr;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            bus.rsp_valid <= enter_resp;
            bus.rsp_err   <= enter_resp && acc_err;
            // rsp_rdata holds between responses; only reads without error
            // return memory contents.
            if (enter_resp) begin
                bus.rsp_rdata <= (acc_wr || acc_err) ? 32'h0 : rd_word;
            end
            if (enter_resp && acc_err) begin
                bus.err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: one instance with WAIT_STATES=2 (dut2)
// and one with WAIT_STATES=0 (dut0), both DEPTH_BYTES=1024, sharing clk/rst.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int SEL2 = 2;  // WAIT_STATES=2 instance
    localparam int SEL0 = 0;  // WAIT_STATES=0 instance

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if #(.ADDR_WIDTH(32)) bus2 ();
    dmem_responder_if #(.ADDR_WIDTH(32)) bus0 ();

    dmem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(2), .ADDR_WIDTH(32)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    dmem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0), .ADDR_WIDTH(32)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic drive(input int sel, input logic v, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel == SEL2) begin
            bus2.req_valid = v; bus2.req_wr = wr; bus2.req_addr = addr; bus2.req_wdata = wdata;
        end else begin
            bus0.req_valid = v; bus0.req_wr = wr; bus0.req_addr = addr; bus0.req_wdata = wdata;
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == SEL2) ? bus2.req_ready : bus0.req_ready;
    endfunction

    function automatic logic rsp_of(input int sel);
        return (sel == SEL2) ? bus2.rsp_valid : bus0.rsp_valid;
    endfunction

    // One complete transaction. Called and returns at posedge+1.
    // acc_cyc: cycle stamp of the accept edge; lat: edges from accept until
    // rsp_valid is seen (1 = visible right after the accept edge).
    task automatic do_req(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int acc_cyc, output int lat,
                          output logic [31:0] rdata, output logic err);
        int n;
        drive(sel, 1'b1, wr, addr, wdata);
        n = 0;
        while (!ready_of(sel) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 1;
        while (!rsp_of(sel) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata = (sel == SEL2) ? bus2.rsp_rdata : bus0.rsp_rdata;
        err   = (sel == SEL2) ? bus2.rsp_err   : bus0.rsp_err;
    endtask

    task automatic test_reset();
        checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus2.req_ready); end
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus2.rsp_valid); end
        checks++; if (bus2.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus2.rsp_rdata); end
        checks++; if (bus2.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", bus2.rsp_err); end
        checks++; if (bus2.err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", bus2.err_sticky); end
        checks++; if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0: got %b expected 1", bus0.req_ready); end
    endtask

    task automatic test_basic();
        int a1, a2, lat;
        logic [31:0] rd;
        logic err;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        do_req(SEL2, 1'b1, 32'd8, 32'hDEADBEEF, a1, lat, rd, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_wr_lat: got %0d expected 3", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b expected 0", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL basic_wr_rdata: got %h expected 0", rd); end
        do_req(SEL2, 1'b0, 32'd8, 32'h0, a2, lat, rd, err);
        checks++; if (a2 - a1 !== 4) begin errors++; $display("FAIL basic_spacing: got %0d expected 4", a2 - a1); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_rd_lat: got %0d expected 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b expected 0", err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut2.u_array.mem[8 + i] !== exp_b[i]) begin
                errors++; $display("FAIL basic_byte%0d: got %h expected %h", 8 + i, dut2.u_array.mem[8 + i], exp_b[i]);
            end
        end
    endtask

    task automatic test_zero_wait();
        int a1, a2, a3, lat1, lat2, lat3;
        logic [31:0] rd;
        logic err;
        do_req(SEL0, 1'b1, 32'd0, 32'h01234567, a1, lat1, rd, err);
        do_req(SEL0, 1'b1, 32'd4, 32'h89ABCDEF, a2, lat2, rd, err);
        checks++; if (lat1 !== 1) begin errors++; $display("FAIL zw_lat1: got %0d expected 1", lat1); end
        checks++; if (lat2 !== 1) begin errors++; $display("FAIL zw_lat2: got %0d expected 1", lat2); end
        checks++; if (a2 - a1 !== 2) begin errors++; $display("FAIL zw_spacing: got %0d expected 2", a2 - a1); end
        do_req(SEL0, 1'b0, 32'd4, 32'h0, a3, lat3, rd, err);
        checks++; if (lat3 !== 1) begin errors++; $display("FAIL zw_rd_lat: got %0d expected 1", lat3); end
        checks++; if (rd !== 32'h89ABCDEF) begin errors++; $display("FAIL zw_rd_data: got %h expected 89abcdef", rd); end
        do_req(SEL0, 1'b0, 32'd0, 32'h0, a3, lat3, rd, err);
        checks++; if (rd !== 32'h01234567) begin errors++; $display("FAIL zw_rd0_data: got %h expected 01234567", rd); end
    endtask

    task automatic test_reset_mid();
        int a, lat, seen, n;
        logic [31:0] rd;
        logic err;
        do_req(SEL2, 1'b1, 32'd16, 32'h12345678, a, lat, rd, err);
        drive(SEL2, 1'b1, 1'b1, 32'd16, 32'hCAFEF00D);
        n = 0;
        while (!bus2.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        drive(SEL2, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (bus2.req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_wait: got ready=%b expected 0", bus2.req_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus2.req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus2.req_ready); end
        checks++; if (bus2.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid: got %b expected 0", bus2.rsp_valid); end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus2.rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d responses expected 0", seen); end
        do_req(SEL2, 1'b0, 32'd16, 32'h0, a, lat, rd, err);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL mid_rd_data: got %h expected 12345678", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rd_err: got %b expected 0", err); end
    endtask

    task automatic test_misaligned();
        int a, lat;
        logic [31:0] rd;
        logic err;
        logic [7:0] exp_b [8];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4;
        exp_b[4] = 8'hDE; exp_b[5] = 8'hAD; exp_b[6] = 8'hBE; exp_b[7] = 8'hEF;
        do_req(SEL2, 1'b1, 32'd4, 32'hA1A2A3A4, a, lat, rd, err);
        checks++; if (bus2.err_sticky !== 1'b0) begin errors++; $display("FAIL mis_sticky_pre: got %b expected 0", bus2.err_sticky); end
        do_req(SEL2, 1'b1, 32'd6, 32'h11223344, a, lat, rd, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", rd); end
        checks++; if (bus2.err_sticky !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", bus2.err_sticky); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut2.u_array.mem[4 + i] !== exp_b[i]) begin
                errors++; $display("FAIL mis_byte%0d: got %h expected %h", 4 + i, dut2.u_array.mem[4 + i], exp_b[i]);
            end
        end
        do_req(SEL2, 1'b0, 32'd4, 32'h0, a, lat, rd, err);
        checks++; if (rd !== 32'hA1A2A3A4) begin errors++; $display("FAIL mis_rd4_data: got %h expected a1a2a3a4", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_rd4_err: got %b expected 0", err); end
        checks++; if (bus2.err_sticky !== 1'b1) begin errors++; $display("FAIL mis_sticky_hold: got %b expected 1", bus2.err_sticky); end
    endtask

    task automatic test_out_of_range();
        int a, lat;
        logic [31:0] rd;
        logic err;
        do_req(SEL2, 1'b1, 32'd1020, 32'h0BADF00D, a, lat, rd, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_wr1020_err: got %b expected 0", err); end
        do_req(SEL2, 1'b0, 32'd1024, 32'h0, a, lat, rd, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_1024_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_1024_rdata: got %h expected 0", rd); end
        do_req(SEL2, 1'b0, 32'd1021, 32'h0, a, lat, rd, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_1021_err: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_1021_rdata: got %h expected 0", rd); end
        do_req(SEL2, 1'b0, 32'h80000008, 32'h0, a, lat, rd, err);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_high_err: got %b expected 1", err); end
        do_req(SEL2, 1'b0, 32'd1020, 32'h0, a, lat, rd, err);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_1020_err: got %b expected 0", err); end
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL oor_1020_rdata: got %h expected 0badf00d", rd); end
    endtask

    task automatic test_held_request();
        int a, lat, acc_n, rsp_n;
        logic [31:0] rd;
        logic err;
        logic pre;
        logic [31:0] got [2];
        got[0] = 32'h0; got[1] = 32'h0;
        do_req(SEL2, 1'b1, 32'd32, 32'h01020304, a, lat, rd, err);
        do_req(SEL2, 1'b1, 32'd36, 32'h0A0B0C0D, a, lat, rd, err);
        acc_n = 0;
        rsp_n = 0;
        drive(SEL2, 1'b1, 1'b0, 32'd32, 32'h0);
        for (int i = 0; i < 14; i++) begin
            pre = bus2.req_valid && bus2.req_ready;
            @(posedge clk); #1;
            if (pre) begin
                acc_n++;
                if (acc_n == 1) bus2.req_addr = 32'd36;
                else bus2.req_valid = 1'b0;
            end
            if (bus2.rsp_valid) begin
                if (rsp_n < 2) got[rsp_n] = bus2.rsp_rdata;
                rsp_n++;
            end
        end
        drive(SEL2, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++; if (rsp_n !== 2) begin errors++; $display("FAIL held_rsp_count: got %0d expected 2", rsp_n); end
        checks++; if (acc_n !== 2) begin errors++; $display("FAIL held_acc_count: got %0d expected 2", acc_n); end
        checks++; if (got[0] !== 32'h01020304) begin errors++; $display("FAIL held_first_data: got %h expected 01020304", got[0]); end
        checks++; if (got[1] !== 32'h0A0B0C0D) begin errors++; $display("FAIL held_second_data: got %h expected 0a0b0c0d", got[1]); end
    endtask

    initial begin
        drive(SEL2, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(SEL0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_zero_wait();
        test_reset_mid();
        test_misaligned();
        test_out_of_range();
        test_held_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
